// File: rtl/vga_window_compositor.sv
// vga_window_compositor: overlays up to N_WIN programmable rectangles on a
// positioned camera video region, two-stage pixel pipeline.
// Window geometry is written into shadow registers and copied to the active
// set on the frame-start pulse, so a frame never shows a half-updated window.
// Optional build macro: VGA_WINDOW_ALPHA_EN (CTRL bit3 = 50% alpha blend).
// Config port: iCfg_we is a single-cycle write strobe that is always accepted
// (no ready); invalid field codes / window indices are dropped silently.
module vga_window_compositor #(
    parameter int              CW           = 10,
    parameter int              N_WIN        = 4,
    parameter int              H_ACTIVE     = 640,
    parameter int              V_ACTIVE     = 480,
    parameter int              VIDEO_X0     = 45,
    parameter int              VIDEO_Y0     = 139,
    parameter int              VIDEO_W      = 550,
    parameter int              VIDEO_H      = 380,
    parameter logic [CW-1:0]   FG_COLOR     = '1,
    parameter logic [CW-1:0]   BG_COLOR     = '0,
    parameter int              BLINK_FRAMES = 30,
    localparam int             AW           = 3 + $clog2(N_WIN)
) (
    input  logic          iCLK,
    input  logic          iRST_N,
    input  logic          iFrame_start,
    input  logic          iVideo_On,
    input  logic [10:0]   iVga_x,
    input  logic [10:0]   iVga_y,
    input  logic [CW-1:0] iRed,
    input  logic [CW-1:0] iGreen,
    input  logic [CW-1:0] iBlue,
    input  logic          iCfg_we,
    input  logic [AW-1:0] iCfg_addr,
    input  logic [10:0]   iCfg_data,
    output logic [CW-1:0] oRed,
    output logic [CW-1:0] oGreen,
    output logic [CW-1:0] oBlue,
    output logic          oPend
);

`ifdef VGA_WINDOW_ALPHA_EN
    localparam int CTRLW = 4;
`else
    localparam int CTRLW = 3;
`endif
    localparam int BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [11:0] L_VX0 = 12'(VIDEO_X0);
    localparam logic [11:0] L_VX1 = 12'(VIDEO_X0 + VIDEO_W);
    localparam logic [11:0] L_VY0 = 12'(VIDEO_Y0);
    localparam logic [11:0] L_VY1 = 12'(VIDEO_Y0 + VIDEO_H);
    localparam logic [11:0] L_HA  = 12'(H_ACTIVE);
    localparam logic [11:0] L_VA  = 12'(V_ACTIVE);

    // Shadow (written by config) and active (used for hit tests) window sets
    logic [10:0]      r_sh_x0 [N_WIN];
    logic [10:0]      r_sh_y0 [N_WIN];
    logic [10:0]      r_sh_w  [N_WIN];
    logic [10:0]      r_sh_h  [N_WIN];
    logic [CTRLW-1:0] r_sh_ctrl [N_WIN];
    logic [10:0]      r_ac_x0 [N_WIN];
    logic [10:0]      r_ac_y0 [N_WIN];
    logic [10:0]      r_ac_w  [N_WIN];
    logic [10:0]      r_ac_h  [N_WIN];
    logic [CTRLW-1:0] r_ac_ctrl [N_WIN];

    logic             r_pend;
    logic [BCW-1:0]   r_blink_cnt;
    logic             r_blink_ph;

    logic [AW-1:0]    w_idx;
    logic [2:0]       w_field;
    logic             w_wr_ok;
    logic             w_commit;
    logic             w_blink_wrap;
    logic             w_blink_ph;
    logic [11:0]      w_x12;
    logic [11:0]      w_y12;
    logic [N_WIN-1:0] w_hit;
    logic [N_WIN-1:0] w_inv;

    // Stage 1 registers
    logic [N_WIN-1:0] r_hit;
    logic [N_WIN-1:0] r_inv;
    logic             r_vid_on;
    logic             r_act;
    logic [CW-1:0]    r_vid_r, r_vid_g, r_vid_b;
`ifdef VGA_WINDOW_ALPHA_EN
    logic [N_WIN-1:0] w_alpha;
    logic [N_WIN-1:0] r_alpha;
`endif

    // Stage 2 colour select and output registers
    logic [CW-1:0]    w_col_r, w_col_g, w_col_b;
    logic [CW-1:0]    r_out_r, r_out_g, r_out_b;

    assign w_idx        = iCfg_addr >> 3;
    assign w_field      = iCfg_addr[2:0];
    assign w_wr_ok      = iCfg_we && (w_field <= 3'd4) && (w_idx < AW'(N_WIN));
    assign w_commit     = iFrame_start && r_pend;
    assign w_blink_wrap = (r_blink_cnt == BCW'(BLINK_FRAMES - 1));
    // On the frame-start cycle itself the pixel already belongs to the new
    // frame, so it sees the committing set and the updated blink phase.
    assign w_blink_ph   = (iFrame_start && w_blink_wrap) ? ~r_blink_ph : r_blink_ph;
    assign w_x12        = {1'b0, iVga_x};
    assign w_y12        = {1'b0, iVga_y};

    for (genvar g = 0; g < N_WIN; g++) begin : g_win
        logic [10:0]      w_x0, w_y0, w_w, w_h;
        logic [CTRLW-1:0] w_ctrl;
        logic [11:0]      w_x_end, w_y_end;
        assign w_x0    = w_commit ? r_sh_x0[g]   : r_ac_x0[g];
        assign w_y0    = w_commit ? r_sh_y0[g]   : r_ac_y0[g];
        assign w_w     = w_commit ? r_sh_w[g]    : r_ac_w[g];
        assign w_h     = w_commit ? r_sh_h[g]    : r_ac_h[g];
        assign w_ctrl  = w_commit ? r_sh_ctrl[g] : r_ac_ctrl[g];
        assign w_x_end = {1'b0, w_x0} + {1'b0, w_w};
        assign w_y_end = {1'b0, w_y0} + {1'b0, w_h};
        assign w_hit[g] = w_ctrl[0] && (!w_ctrl[1] || w_blink_ph)
                       && (w_x12 >= {1'b0, w_x0}) && (w_x12 < w_x_end)
                       && (w_y12 >= {1'b0, w_y0}) && (w_y12 < w_y_end);
        assign w_inv[g] = w_ctrl[2];
`ifdef VGA_WINDOW_ALPHA_EN
        assign w_alpha[g] = w_ctrl[3];
`endif
    end

`ifdef VGA_WINDOW_ALPHA_EN
    function automatic logic [CW-1:0] f_blend(input logic [CW-1:0] v);
        logic [CW:0] s;
        s = {1'b0, FG_COLOR} + {1'b0, v};
        return s[CW:1];
    endfunction
`endif

    // Shadow registers: accept config writes to valid fields
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            for (int i = 0; i < N_WIN; i++) begin
                r_sh_x0[i] <= '0; r_sh_y0[i] <= '0; r_sh_w[i] <= '0;
                r_sh_h[i]  <= '0; r_sh_ctrl[i] <= '0;
            end
        end else if (w_wr_ok) begin
            for (int i = 0; i < N_WIN; i++) begin
                if (w_idx == AW'(i)) begin
                    case (w_field)
                        3'd0:    r_sh_x0[i]   <= iCfg_data;
                        3'd1:    r_sh_y0[i]   <= iCfg_data;
                        3'd2:    r_sh_w[i]    <= iCfg_data;
                        3'd3:    r_sh_h[i]    <= iCfg_data;
                        3'd4:    r_sh_ctrl[i] <= iCfg_data[CTRLW-1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // Active set: copy the whole shadow set at a frame start with a pending commit
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            for (int i = 0; i < N_WIN; i++) begin
                r_ac_x0[i] <= '0; r_ac_y0[i] <= '0; r_ac_w[i] <= '0;
                r_ac_h[i]  <= '0; r_ac_ctrl[i] <= '0;
            end
        end else if (w_commit) begin
            for (int i = 0; i < N_WIN; i++) begin
                r_ac_x0[i] <= r_sh_x0[i]; r_ac_y0[i] <= r_sh_y0[i];
                r_ac_w[i]  <= r_sh_w[i];  r_ac_h[i]  <= r_sh_h[i];
                r_ac_ctrl[i] <= r_sh_ctrl[i];
            end
        end
    end

    // Pending flag: a write in the commit cycle keeps it set for the next frame
    always_ff @(posedge iCLK) begin
        if (!iRST_N)       r_pend <= 1'b0;
        else if (w_wr_ok)  r_pend <= 1'b1;
        else if (w_commit) r_pend <= 1'b0;
    end

    // Blink frame counter and visibility phase
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b1;
        end else if (iFrame_start) begin
            if (w_blink_wrap) begin
                r_blink_cnt <= '0;
                r_blink_ph  <= ~r_blink_ph;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    // Stage 1: register hit vector, region flags and the video pixel
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_hit <= '0; r_inv <= '0; r_vid_on <= 1'b0; r_act <= 1'b0;
            r_vid_r <= '0; r_vid_g <= '0; r_vid_b <= '0;
`ifdef VGA_WINDOW_ALPHA_EN
            r_alpha <= '0;
`endif
        end else begin
            r_hit    <= w_hit;
            r_inv    <= w_inv;
            r_vid_on <= iVideo_On && (w_x12 >= L_VX0) && (w_x12 < L_VX1)
                                  && (w_y12 >= L_VY0) && (w_y12 < L_VY1);
            r_act    <= (w_x12 < L_HA) && (w_y12 < L_VA);
            r_vid_r  <= iRed; r_vid_g <= iGreen; r_vid_b <= iBlue;
`ifdef VGA_WINDOW_ALPHA_EN
            r_alpha  <= w_alpha;
`endif
        end
    end

    // Priority select: lowest-index window, then video, then background
    always_comb begin
        w_col_r = BG_COLOR; w_col_g = BG_COLOR; w_col_b = BG_COLOR;
        if (r_act) begin
            if (r_vid_on) begin
                w_col_r = r_vid_r; w_col_g = r_vid_g; w_col_b = r_vid_b;
            end
            // Walk from the highest index down so the lowest hit wins
            for (int i = N_WIN - 1; i >= 0; i--) begin
                if (r_hit[i]) begin
                    if (r_inv[i]) begin
                        w_col_r = ~r_vid_r; w_col_g = ~r_vid_g; w_col_b = ~r_vid_b;
                    end
`ifdef VGA_WINDOW_ALPHA_EN
                    else if (r_alpha[i]) begin
                        w_col_r = f_blend(r_vid_r);
                        w_col_g = f_blend(r_vid_g);
                        w_col_b = f_blend(r_vid_b);
                    end
`endif
                    else begin
                        w_col_r = FG_COLOR; w_col_g = FG_COLOR; w_col_b = FG_COLOR;
                    end
                end
            end
        end
    end

    // Stage 2: register the composited colour
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_out_r <= '0; r_out_g <= '0; r_out_b <= '0;
        end else begin
            r_out_r <= w_col_r; r_out_g <= w_col_g; r_out_b <= w_col_b;
        end
    end

    assign oRed   = r_out_r;
    assign oGreen = r_out_g;
    assign oBlue  = r_out_b;
    assign oPend  = r_pend;

endmodule

// File: tb/tb_vga_window_compositor.sv
// Bench for vga_window_compositor: directed scans plus randomized traffic,
// compared against a rule-level reference model of windows/video/background.
module tb_vga_window_compositor;
  localparam int CW    = 10;
  localparam int N_WIN = 4;
  localparam int BF    = 2;
  localparam int AW    = 5;
  localparam logic [CW-1:0] FG = '1;
  localparam logic [CW-1:0] BG = '0;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          frame_start = 1'b0;
  logic          video_on = 1'b0;
  logic [10:0]   vga_x = '0, vga_y = '0;
  logic [CW-1:0] in_r = '0, in_g = '0, in_b = '0;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [10:0]   cfg_data = '0;
  logic [CW-1:0] out_r, out_g, out_b;
  logic          pend;

  vga_window_compositor #(.CW(CW), .N_WIN(N_WIN), .BLINK_FRAMES(BF)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iFrame_start(frame_start), .iVideo_On(video_on),
    .iVga_x(vga_x), .iVga_y(vga_y), .iRed(in_r), .iGreen(in_g), .iBlue(in_b),
    .iCfg_we(cfg_we), .iCfg_addr(cfg_addr), .iCfg_data(cfg_data),
    .oRed(out_r), .oGreen(out_g), .oBlue(out_b), .oPend(pend)
  );

  // scoreboard state
  int n_checks = 0;
  int n_errors = 0;
  logic [3*CW-1:0] exp_q[$];
  string tag = "reset";

  // reference model: fields 0=X0 1=Y0 2=W 3=H 4=CTRL
  int m_sh[N_WIN][5];
  int m_ac[N_WIN][5];
  bit m_pend;
  int m_pulses;
  logic [CW-1:0] t_r, t_g, t_b;
  bit t_von;

  int xs[11] = '{0, 44, 45, 46, 300, 593, 594, 595, 639, 640, 700};
  int ys[10] = '{0, 138, 139, 140, 300, 479, 480, 517, 518, 519};

  function automatic bit win_hit(int i, int x, int y);
    int c;
    c = m_ac[i][4];
    if ((c & 1) == 0) return 0;
    if (((c >> 1) & 1) == 1 && ((m_pulses / BF) % 2) != 0) return 0;
    return x >= m_ac[i][0] && x < m_ac[i][0] + m_ac[i][2] &&
           y >= m_ac[i][1] && y < m_ac[i][1] + m_ac[i][3];
  endfunction

  function automatic logic [CW-1:0] exp_chan(int x, int y, logic [CW-1:0] v, bit von);
    if (x >= 640 || y >= 480) return BG;
    for (int i = 0; i < N_WIN; i++) begin
      if (win_hit(i, x, y)) begin
        if (((m_ac[i][4] >> 2) & 1) == 1) return ~v;
`ifdef VGA_WINDOW_ALPHA_EN
        if (((m_ac[i][4] >> 3) & 1) == 1) return CW'((int'(FG) + int'(v)) / 2);
`endif
        return FG;
      end
    end
    if (von && x >= 45 && x < 45 + 550 && y >= 139 && y < 139 + 380) return v;
    return BG;
  endfunction

  // driver: one pixel clock with the given inputs; checks the output that
  // belongs to the pixel driven two clocks earlier, and the pending flag
  task automatic step(input int x, input int y, input bit fs, input bit we,
                      input int addr, input int data);
    logic [3*CW-1:0] e;
    logic [3*CW-1:0] got;
    vga_x = 11'(x); vga_y = 11'(y);
    frame_start = fs; cfg_we = we;
    cfg_addr = AW'(addr); cfg_data = 11'(data);
    in_r = t_r; in_g = t_g; in_b = t_b; video_on = t_von;
    if (fs) begin
      m_pulses++;
      if (m_pend) begin
        m_ac = m_sh;
        m_pend = 0;
      end
    end
    if (we && (addr % 8) <= 4 && (addr / 8) < N_WIN) begin
      m_sh[addr / 8][addr % 8] = data & 16'h07FF;
      m_pend = 1;
    end
    e = {exp_chan(x, y, t_r, t_von), exp_chan(x, y, t_g, t_von), exp_chan(x, y, t_b, t_von)};
    exp_q.push_back(e);
    @(posedge clk); #1;
    n_checks++;
    assert (pend === m_pend) else begin
      n_errors++;
      $error("FAIL %s pend got=%0b exp=%0b", tag, pend, m_pend);
    end
    if (exp_q.size() >= 2) begin
      got = {out_r, out_g, out_b};
      e = exp_q.pop_front();
      n_checks++;
      assert (got === e) else begin
        n_errors++;
        $error("FAIL %s colour got=%h exp=%h", tag, got, e);
      end
    end
  endtask

  task automatic px(input int x, input int y);
    step(x, y, 0, 0, 0, 0);
  endtask

  task automatic wr(input int idx, input int f, input int d);
    step($urandom_range(0, 760), $urandom_range(0, 540), 0, 1, idx * 8 + f, d);
  endtask

  task automatic frm();
    step(0, 0, 1, 0, 0, 0);
  endtask

  task automatic win(input int idx, input int x0, input int y0, input int w,
                     input int h, input int c);
    wr(idx, 0, x0); wr(idx, 1, y0); wr(idx, 2, w); wr(idx, 3, h); wr(idx, 4, c);
  endtask

  task automatic row(input int x_lo, input int x_hi, input int y);
    for (int x = x_lo; x <= x_hi; x++) px(x, y);
  endtask

  // reset with random traffic (including writes) that must have no effect
  task automatic do_reset(input int n);
    logic [3*CW:0] got;
    rst_n = 1'b0;
    repeat (n) begin
      vga_x = 11'($urandom_range(0, 700)); vga_y = 11'($urandom_range(0, 500));
      frame_start = 1'($urandom_range(0, 1)); cfg_we = 1'b1;
      cfg_addr = AW'($urandom_range(0, 31)); cfg_data = 11'($urandom_range(0, 2047));
      @(posedge clk); #1;
      got = {out_r, out_g, out_b, pend};
      n_checks++;
      assert (got === '0) else begin
        n_errors++;
        $error("FAIL reset outputs got=%h exp=0", got);
      end
    end
    for (int i = 0; i < N_WIN; i++)
      for (int f = 0; f < 5; f++) begin
        m_sh[i][f] = 0;
        m_ac[i][f] = 0;
      end
    m_pend = 0;
    m_pulses = 0;
    exp_q.delete();
    exp_q.push_back('0);  // first clock after release still shows the cleared pipeline
    rst_n = 1'b1;
  endtask

  initial begin
    int a;
    int d;
    // video-region scan
    t_r = 10'h155; t_g = 10'h155; t_b = 10'h155; t_von = 1;
    do_reset(3);
    tag = "video_scan";
    for (int j = 0; j < 10; j++)
      for (int i = 0; i < 11; i++) px(xs[i], ys[j]);
    px(44, 200); px(45, 200); px(46, 200); px(44, 200);
    for (int i = 0; i < 200; i++) px($urandom_range(0, 760), $urandom_range(0, 540));

    // single window and commit
    tag = "win0";
    win(0, 100, 20, 50, 10, 1);
    px(120, 25);
    frm();
    for (int y = 19; y <= 30; y++) row(98, 152, y);

    // overlap
    tag = "overlap";
    win(1, 120, 25, 50, 10, 1);
    frm();
    px(130, 25); px(130, 34); px(130, 35);
    row(145, 172, 25); row(145, 172, 34); row(145, 172, 35);

    // mid-frame width change and same-cycle write with frame start
    tag = "midframe_w";
    wr(0, 2, 60);
    row(146, 172, 22);
    frm();
    row(146, 172, 22);
    tag = "same_cycle";
    step(0, 0, 1, 1, 0 * 8 + 2, 70);
    row(146, 172, 22);
    frm();
    row(146, 172, 22);

    // blink (mid-run reset first)
    tag = "blink";
    do_reset(2);
    win(2, 300, 300, 20, 20, 3);
    px(310, 310);
    for (int f = 0; f < 7; f++) begin
      frm();
      px(299, 305); px(300, 305); px(310, 310); px(319, 319); px(320, 319);
    end

    // invert window over video, then video off
    tag = "invert";
    t_r = 10'h0F0; t_g = 10'h0F0; t_b = 10'h0F0;
    win(3, 40, 130, 30, 30, 5);
    frm();
    for (int k = 0; k < 2; k++) begin
      t_von = (k == 0);
      px(39, 135); px(40, 135); px(44, 140); px(45, 139); px(50, 150);
      px(69, 159); px(70, 150); px(100, 200); px(700, 150); px(700, 200);
    end
    t_von = 1;

    // invalid field codes are ignored
    tag = "bad_field";
    frm();
    wr(1, 5, 7); wr(2, 6, 7); wr(3, 7, 7);
    px(130, 25);

    // randomized traffic
    tag = "random";
    for (int n = 0; n < 3000; n++) begin
      t_r = CW'($urandom); t_g = CW'($urandom); t_b = CW'($urandom);
      t_von = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) begin
        a = $urandom_range(0, 31);
        case (a % 8)
          2, 3:    d = $urandom_range(0, 300);
          4:       d = $urandom_range(0, 15);
          default: d = $urandom_range(0, 760);
        endcase
        step($urandom_range(0, 760), $urandom_range(0, 540),
             $urandom_range(0, 39) == 0, 1, a, d);
      end else begin
        step($urandom_range(0, 760), $urandom_range(0, 540),
             $urandom_range(0, 39) == 0, 0, 0, 0);
      end
    end
    px(0, 0); px(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/vga_window_compositor.md
Name: vga_window_compositor

Overview:
- Parametrised successor to the fixed single-banner VGA overlay.
- Composites up to N_WIN runtime-programmable rectangular windows over a positioned camera video region.
- Window geometry is double-buffered: config writes land in shadow registers and commit only at frame start, so windows never tear mid-frame.
- Sits between the camera/scaler pixel path and the VGA DAC outputs, in the same clock domain as the VGA timing generator.

Parameters:
- CW, 10, colour channel width in bits.
- N_WIN, 4, number of overlay windows (1..8).
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- VIDEO_X0, 45, left edge of the video region.
- VIDEO_Y0, 139, top edge of the video region.
- VIDEO_W, 550, video region width.
- VIDEO_H, 380, video region height.
- FG_COLOR, all-ones, window fill colour (all channels).
- BG_COLOR, 0, background colour (all channels).
- BLINK_FRAMES, 30, frames per blink half-period (>=1).

Ports:
- iCLK  in  1  pixel clock
- iRST_N  in  1  synchronous active-low reset
- iFrame_start  in  1  one-cycle pulse on the first active pixel of each frame
- iVideo_On  in  1  1 = show video region, 0 = background inside the video region
- iVga_x  in  11  current pixel x
- iVga_y  in  11  current pixel y
- iRed/iGreen/iBlue  in  CW each  video pixel aligned with iVga_x/iVga_y
- iCfg_we  in  1  config write strobe
- iCfg_addr  in  3+log2(N_WIN)  {window index, field}; field 0=X0, 1=Y0, 2=W, 3=H, 4=CTRL
- iCfg_data  in  11  field value; CTRL uses bit0=enable, bit1=blink, bit2=invert
- oRed/oGreen/oBlue  out  CW each  composited pixel
- oPend  out  1  shadow differs from active set (commit pending)

Behaviour:
- Reset: one clock, synchronous, active-low.
  - All shadow and active window fields cleared, so every window is disabled.
  - Blink counter = 0, blink phase = 1 (visible).
  - oPend = 0; all outputs = 0; pipeline registers cleared.
  - A reset mid-frame takes effect on the next edge; output is 0 for 2 cycles after release.
- Config writes:
  - iCfg_we writes iCfg_data into the shadow field and sets oPend = 1.
  - Field codes 5..7 and window index >= N_WIN are ignored; oPend is unchanged.
- Commit:
  - On iFrame_start with oPend = 1, all shadow registers are copied to the active set and oPend clears.
  - Write and iFrame_start in the same cycle: the commit uses the pre-write shadow; the write lands in the shadow; oPend stays 1 and commits next frame.
- Blink:
  - The counter increments on each iFrame_start.
  - On reaching BLINK_FRAMES-1 the counter wraps to 0 and the phase toggles.
  - Blink windows are hit-eligible only while phase = 1.
- Pipeline, latency 2 cycles (coordinates/video in to colour out):
  - Stage 1 registers the per-window hit vector, the video-region hit, and the delayed video pixel.
  - Window hit: enable & x >= X0 & x < X0+W & y >= Y0 & y < Y0+H, with sums computed in 12 bits (no wrap). W = 0 or H = 0 never hits.
  - Stage 2 registers the priority-selected colour.
- Priority, highest first:
  1. Lowest-index hit window: FG_COLOR, or bitwise-inverted video pixel if its invert bit is set (inversion applies even outside the video region).
  2. Video region with iVideo_On = 1: video pixel.
  3. BG_COLOR.
- Pixels with x >= H_ACTIVE or y >= V_ACTIVE output BG_COLOR regardless of window or video hits.
- iVideo_On is sampled in stage 1, so toggling it mid-line takes effect with the same 2-cycle latency.

Optional Feature:
- Macro: VGA_WINDOW_ALPHA_EN.
- Defined:
  - CTRL bit3 = alpha.
  - An alpha window's output is (FG + video) >> 1 per channel, computed with a CW+1-bit sum.
  - Invert takes precedence over alpha.
  - Latency remains 2 cycles.
- Undefined: CTRL bit3 is ignored and windows are opaque.

Test Plan:
- Reset, then scan a full frame with iVideo_On = 1 and video = 0x155 -> 0x155 exactly at x 45..594, y 139..518; 0 elsewhere; 2-cycle latency checked at x = 45.
- Program window 0 = (100, 20, 50, 10) with enable, then pulse iFrame_start -> oPend goes 1 then 0; pixels x 100..149, y 20..29 = 0x3FF; x = 150 = BG.
- Overlap: window 1 = (120, 25, 50, 10) enabled; window 0 as above -> pixel (130, 25) shows window 0; window 1 alone covers x 150..169.
- Write window 0 W = 60 mid-frame -> the current frame still ends at x = 149; the next frame ends at x = 159; a write in the same cycle as iFrame_start defers one frame.
- Blink window with BLINK_FRAMES = 2 -> visible for frames 0-1, hidden for frames 2-3, visible for frame 4.
- Invert window over video 0x0F0 -> 0x30F; with iVideo_On = 0, pixels outside windows inside the video region = BG; x = 700 always = BG.
